// File: rtl/video_pixel_pack.sv
// video_pixel_pack: RGB565 video stream packer.
// In RGB mode each active pixel passes through unchanged. In grey mode each
// pixel is reduced to an 8-bit luma byte and pixel pairs are packed into one
// 16-bit word. Line/frame counters and a sticky line-length error flag track
// the incoming timing. All data paths have a fixed two-register latency.
module video_pixel_pack #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        grey_mode,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [15:0] in_data,
    output logic        out_vs,
    output logic        out_de,
    output logic [15:0] out_data,
    output logic        run_mode,
    output logic [10:0] line_cnt,
    output logic [15:0] frame_cnt,
    output logic        err_line
);

    localparam int          VS_DELAY = 2;
    localparam logic [10:0] H_LIMIT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIMIT  = 11'(V_ACTIVE);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;

    // Registered state
    logic [VS_DELAY-1:0] vs_pipe_reg;
    logic                vs_prev_reg;
    logic                de_prev_reg;
    logic                skip_reg;
    logic                phase_reg;
    logic [10:0]         pix_cnt_reg;
    logic [10:0]         line_cnt_reg;
    logic [15:0]         frame_cnt_reg;
    logic                run_mode_reg;
    logic                err_reg;
    logic [7:0]          even_y_reg;
    logic                s1_valid_reg;
    logic [15:0]         s1_data_reg;
    logic                out_de_reg;
    logic [15:0]         out_data_reg;

    // Next-state values
    logic                skip_next;
    logic                phase_next;
    logic [10:0]         pix_cnt_next;
    logic [10:0]         line_cnt_next;
    logic                err_next;
    logic                s1_valid_next;
    logic [15:0]         s1_data_next;

    // Decoded events
    logic                vs_rise;
    logic                pix_ok;
    logic                de_fall;
    logic                pad_word;

    // Luma path
    logic [4:0]          r_val;
    logic [5:0]          g_val;
    logic [4:0]          b_val;
    logic [12:0]         y_sum;
    logic [7:0]          y_byte;

    assign r_val  = in_data[15:11];
    assign g_val  = in_data[10:5];
    assign b_val  = in_data[4:0];
    // Worst case 31*76 + 63*75 + 31*29 = 7980, so 13 bits never overflow
    assign y_sum  = ({8'd0, r_val} * 13'd76) + ({7'd0, g_val} * 13'd75) + ({8'd0, b_val} * 13'd29);
    assign y_byte = y_sum[12:5];

    assign vs_rise  = in_vs & ~vs_prev_reg;
    // A frame start aborts any line in flight; skip_reg then masks the rest of
    // that burst (and any burst already running when reset was released).
    assign pix_ok   = in_de & ~skip_reg & ~vs_rise;
    // de_prev_reg tracks accepted pixels, so aborted bursts never produce a fall
    assign de_fall  = ~in_de & de_prev_reg;
    // Odd-length grey line: flush the held even byte with a zero high byte
    assign pad_word = de_fall & phase_reg & run_mode_reg & ~vs_rise;

    // Next-state logic for line tracking, counters and the error flag
    always_comb begin
        skip_next     = in_de & (skip_reg | vs_rise);
        phase_next    = pix_ok & run_mode_reg & ~phase_reg;
        pix_cnt_next  = 11'd0;
        line_cnt_next = line_cnt_reg;
        err_next      = err_reg;

        if (pix_ok) begin
            pix_cnt_next = (pix_cnt_reg == CNT_MAX) ? CNT_MAX : pix_cnt_reg + 11'd1;
        end

        if (vs_rise) begin
            line_cnt_next = 11'd0;
        end else if (de_fall && (line_cnt_reg != CNT_MAX)) begin
            line_cnt_next = line_cnt_reg + 11'd1;
        end

        // Frame start clears the flag and takes priority over any new violation
        if (vs_rise) begin
            err_next = 1'b0;
        end else if ((pix_ok && (pix_cnt_reg == H_LIMIT)) ||
                     (de_fall && (pix_cnt_reg != H_LIMIT)) ||
                     (de_fall && (line_cnt_reg == V_LIMIT))) begin
            err_next = 1'b1;
        end
    end

    // First pipeline stage: select passthrough pixel, packed pair or pad word
    always_comb begin
        s1_valid_next = 1'b0;
        s1_data_next  = 16'h0000;
        if (run_mode_reg) begin
            if (pix_ok && phase_reg) begin
                s1_valid_next = 1'b1;
                s1_data_next  = {y_byte, even_y_reg};
            end else if (pad_word) begin
                s1_valid_next = 1'b1;
                s1_data_next  = {8'h00, even_y_reg};
            end
        end else if (pix_ok) begin
            s1_valid_next = 1'b1;
            s1_data_next  = in_data;
        end
    end

    // Frame/line control state: edge history, mode latch, counters, error flag
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_reg   <= 1'b0;
            de_prev_reg   <= 1'b0;
            skip_reg      <= 1'b1;  // ignore a burst already active at release
            phase_reg     <= 1'b0;
            pix_cnt_reg   <= 11'd0;
            line_cnt_reg  <= 11'd0;
            frame_cnt_reg <= 16'd0;
            run_mode_reg  <= 1'b0;
            err_reg       <= 1'b0;
            even_y_reg    <= 8'd0;
        end else begin
            vs_prev_reg  <= in_vs;
            de_prev_reg  <= pix_ok;
            skip_reg     <= skip_next;
            phase_reg    <= phase_next;
            pix_cnt_reg  <= pix_cnt_next;
            line_cnt_reg <= line_cnt_next;
            err_reg      <= err_next;
            if (vs_rise) begin
                run_mode_reg  <= grey_mode;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (pix_ok && run_mode_reg && !phase_reg) begin
                even_y_reg <= y_byte;
            end
        end
    end

    // Two-stage data pipeline and frame sync delay line
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe_reg  <= '0;
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= 16'h0000;
            out_de_reg   <= 1'b0;
            out_data_reg <= 16'h0000;
        end else begin
            vs_pipe_reg  <= {vs_pipe_reg[VS_DELAY-2:0], in_vs};
            s1_valid_reg <= s1_valid_next;
            s1_data_reg  <= s1_data_next;
            out_de_reg   <= s1_valid_reg;
            out_data_reg <= s1_valid_reg ? s1_data_reg : 16'h0000;
        end
    end

    assign out_vs    = vs_pipe_reg[VS_DELAY-1];
    assign out_de    = out_de_reg;
    assign out_data  = out_data_reg;
    assign run_mode  = run_mode_reg;
    assign line_cnt  = line_cnt_reg;
    assign frame_cnt = frame_cnt_reg;
    assign err_line  = err_reg;

endmodule
